// File: rtl/slow_vram_pkg.sv
// Shared widths, frame arithmetic, slot phase roles and slot-owner encoding
// for the slow VRAM time-slot scheduler.
package slow_vram_pkg;

    localparam int PH_ADDR     = 0;
    localparam int PH_WE_FIRST = 1;

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_FETCH,
        OWN_CPU_RD,
        OWN_CPU_WR
    } slot_own_e;

    function automatic int SLOT_W(input int nch);
        return (nch < 1) ? 1 : $clog2(nch + 1);
    endfunction

    function automatic int PHASE_W(input int slot_len);
        return (slot_len < 2) ? 1 : $clog2(slot_len);
    endfunction

    function automatic int FRAME_LEN(input int nch, input int slot_len);
        return (nch + 1) * slot_len;
    endfunction

    // Last phase of a slot: read data is captured on its closing edge.
    function automatic int PH_CAPTURE(input int slot_len);
        return slot_len - 1;
    endfunction

endpackage

// File: rtl/slow_vram_slot_timer.sv
// Phase and slot counters for the VRAM frame; slot_start marks phase 0,
// slot_end marks the capture phase that closes each slot.
module slow_vram_slot_timer
    import slow_vram_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int SLOT_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [PHASE_W(SLOT_LEN)-1:0] phase,
    output logic [SLOT_W(NCH)-1:0]       slot,
    output logic                        slot_start,
    output logic                        slot_end
);

    localparam int PW = PHASE_W(SLOT_LEN);
    localparam int SW = SLOT_W(NCH);

    assign slot_start = (phase == PW'(PH_ADDR));
    assign slot_end   = (phase == PW'(PH_CAPTURE(SLOT_LEN)));

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            slot  <= '0;
        end else if (slot_end) begin
            phase <= '0;
            slot  <= (slot == SW'(NCH)) ? '0 : slot + SW'(1);
        end else begin
            phase <= phase + PW'(1);
        end
    end

endmodule

// File: rtl/slow_vram_scheduler.sv
// Time-slot sequencer for the slow VRAM bank: NCH fetch slots plus one CPU slot.
// Build option SLOW_VRAM_AUTOINC_EN adds the CPU address pointer (CPU_ALD/CPU_MOD).
module slow_vram_scheduler
    import slow_vram_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int NCH      = 3,
    parameter int SLOT_LEN = 4
) (
    input  logic                    CLK_24M,
    input  logic                    RESETP,
    input  logic [NCH-1:0]          FETCH_EN,
    input  logic [NCH*ADDR_W-1:0]   FETCH_ADDR,
    output logic [NCH*DATA_W-1:0]   FETCH_DATA,
    output logic [NCH-1:0]          FETCH_VALID,
    input  logic                    CPU_REQ,
    input  logic                    CPU_WR,
    input  logic [ADDR_W-1:0]       CPU_ADDR,
    input  logic [DATA_W-1:0]       CPU_WDATA,
`ifdef SLOW_VRAM_AUTOINC_EN
    input  logic                    CPU_ALD,
    input  logic [ADDR_W-1:0]       CPU_MOD,
`endif
    output logic                    CPU_BUSY,
    output logic                    CPU_DONE,
    output logic [DATA_W-1:0]       CPU_RDATA,
    output logic [SLOT_W(NCH)-1:0]  SLOT,
    output logic [ADDR_W-1:0]       MEM_ADDR,
    output logic [DATA_W-1:0]       MEM_WDATA,
    input  logic [DATA_W-1:0]       MEM_RDATA,
    output logic                    MEM_OE,
    output logic                    MEM_WE
);

    localparam int PW = PHASE_W(SLOT_LEN);
    localparam int SW = SLOT_W(NCH);

    logic [PW-1:0] phase;
    logic [SW-1:0] slot;
    logic          slot_start;
    logic          slot_end;

    slow_vram_slot_timer #(
        .NCH      (NCH),
        .SLOT_LEN (SLOT_LEN)
    ) u_timer (
        .clk        (CLK_24M),
        .rst        (RESETP),
        .phase      (phase),
        .slot       (slot),
        .slot_start (slot_start),
        .slot_end   (slot_end)
    );

    assign SLOT = slot;

    logic              busy_q;
    logic              done_q;
    logic              buf_wr;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] fetch_q [NCH];
    logic [NCH-1:0]    valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // own_q: IDLE no access | FETCH channel read | CPU_RD cpu read | CPU_WR cpu write
    slot_own_e own_q;
    slot_own_e own_next;
    slot_own_e own_sampled;
    slot_own_e own_cur;

    logic              cpu_slot;
    logic              fetch_en_sel;
    logic [ADDR_W-1:0] fetch_addr_sel;
    logic [ADDR_W-1:0] own_addr;
    logic              start_active;

    assign cpu_slot = (slot == SW'(NCH));

    always_comb begin
        fetch_en_sel   = 1'b0;
        fetch_addr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (slot == SW'(i)) begin
                fetch_en_sel   = FETCH_EN[i];
                fetch_addr_sel = FETCH_ADDR[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // The owner is decided from live inputs during phase 0, so the bus is valid in phase 0 itself.
    always_comb begin
        own_sampled = OWN_IDLE;
        if (!RESETP) begin
            if (cpu_slot) begin
                if (busy_q)
                    own_sampled = buf_wr ? OWN_CPU_WR : OWN_CPU_RD;
            end else if (fetch_en_sel) begin
                own_sampled = OWN_FETCH;
            end
        end
    end

    always_comb begin
        own_next = own_q;
        if (slot_start)
            own_next = own_sampled;
        else if (slot_end)
            own_next = OWN_IDLE;
    end

    always_ff @(posedge CLK_24M) begin
        if (RESETP)
            own_q <= OWN_IDLE;
        else
            own_q <= own_next;
    end

    assign own_addr     = cpu_slot ? buf_addr : fetch_addr_sel;
    assign own_cur      = slot_start ? own_sampled : own_q;
    assign start_active = slot_start && (own_sampled != OWN_IDLE);

    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (start_active)
                addr_q <= own_addr;
            if (slot_start && (own_sampled == OWN_CPU_WR))
                wdata_q <= buf_wdata;
        end
    end

    assign MEM_ADDR  = start_active ? own_addr : addr_q;
    assign MEM_WDATA = (slot_start && (own_sampled == OWN_CPU_WR)) ? buf_wdata : wdata_q;
    assign MEM_OE    = (own_cur == OWN_FETCH) || (own_cur == OWN_CPU_RD);
    // Write strobe sits inside the slot, leaving address setup and hold phases.
    assign MEM_WE    = (own_cur == OWN_CPU_WR)
                    && (phase >= PW'(PH_WE_FIRST))
                    && (phase <  PW'(PH_CAPTURE(SLOT_LEN)));

    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            for (int i = 0; i < NCH; i++)
                fetch_q[i] <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= '0;
            if (slot_end && (own_q == OWN_FETCH)) begin
                for (int i = 0; i < NCH; i++) begin
                    if (slot == SW'(i)) begin
                        fetch_q[i] <= MEM_RDATA;
                        valid_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_fetch_out
        assign FETCH_DATA[g*DATA_W +: DATA_W] = fetch_q[g];
    end
    assign FETCH_VALID = valid_q;

`ifdef SLOW_VRAM_AUTOINC_EN
    logic [ADDR_W-1:0] ptr_q;
`endif

    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            buf_wr    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            rdata_q   <= '0;
`ifdef SLOW_VRAM_AUTOINC_EN
            ptr_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            // Completion and acceptance never coincide: a request is only taken while idle.
            if (slot_end && ((own_q == OWN_CPU_RD) || (own_q == OWN_CPU_WR))) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                if (own_q == OWN_CPU_RD)
                    rdata_q <= MEM_RDATA;
`ifdef SLOW_VRAM_AUTOINC_EN
                ptr_q <= ptr_q + CPU_MOD;
`endif
            end else if (!busy_q && CPU_REQ) begin
                busy_q    <= 1'b1;
                buf_wr    <= CPU_WR;
                buf_wdata <= CPU_WDATA;
`ifdef SLOW_VRAM_AUTOINC_EN
                if (CPU_ALD) begin
                    ptr_q    <= CPU_ADDR;
                    buf_addr <= CPU_ADDR;
                end else begin
                    buf_addr <= ptr_q;
                end
`else
                buf_addr  <= CPU_ADDR;
`endif
            end
        end
    end

    assign CPU_BUSY  = busy_q;
    assign CPU_DONE  = done_q;
    assign CPU_RDATA = rdata_q;

endmodule

// File: tb/tb_slow_vram_scheduler.sv
// Scoreboard bench for slow_vram_scheduler: fetch and CPU completions are
// predicted when driven and matched when FETCH_VALID / CPU_DONE fire.
module tb_slow_vram_scheduler;
    import slow_vram_pkg::*;

    localparam int AW  = 15;
    localparam int DW  = 16;
    localparam int NCH = 3;
    localparam int SL  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetp;
    logic [NCH-1:0]      fetch_en;
    logic [NCH*AW-1:0]   fetch_addr;
    logic [NCH*DW-1:0]   fetch_data;
    logic [NCH-1:0]      fetch_valid;
    logic                cpu_req, cpu_wr;
    logic [AW-1:0]       cpu_addr;
    logic [DW-1:0]       cpu_wdata;
    logic                cpu_busy, cpu_done;
    logic [DW-1:0]       cpu_rdata;
    logic [SLOT_W(NCH)-1:0] slot;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata, mem_rdata;
    logic                mem_oe, mem_we;
`ifdef SLOW_VRAM_AUTOINC_EN
    logic                cpu_ald;
    logic [AW-1:0]       cpu_mod;
`endif

    slow_vram_scheduler #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .SLOT_LEN(SL)) dut (
        .CLK_24M     (clk),
        .RESETP      (resetp),
        .FETCH_EN    (fetch_en),
        .FETCH_ADDR  (fetch_addr),
        .FETCH_DATA  (fetch_data),
        .FETCH_VALID (fetch_valid),
        .CPU_REQ     (cpu_req),
        .CPU_WR      (cpu_wr),
        .CPU_ADDR    (cpu_addr),
        .CPU_WDATA   (cpu_wdata),
`ifdef SLOW_VRAM_AUTOINC_EN
        .CPU_ALD     (cpu_ald),
        .CPU_MOD     (cpu_mod),
`endif
        .CPU_BUSY    (cpu_busy),
        .CPU_DONE    (cpu_done),
        .CPU_RDATA   (cpu_rdata),
        .SLOT        (slot),
        .MEM_ADDR    (mem_addr),
        .MEM_WDATA   (mem_wdata),
        .MEM_RDATA   (mem_rdata),
        .MEM_OE      (mem_oe),
        .MEM_WE      (mem_we)
    );

    // SRAM model: preloaded with data equal to address
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = DW'(i);
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= resetp ? 0 : cyc + 1;

    typedef struct { int ch; logic [DW-1:0] data; int at; } fexp_t;
    typedef struct { logic rd; logic [DW-1:0] data; int at; } cexp_t;
    fexp_t exp_f[$];
    cexp_t exp_c[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic at_cyc(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc != k && n < 400);
        if (cyc != k) chk("wait_cyc", cyc, k);
    endtask

    task automatic push_f(input int ch, input logic [DW-1:0] d, input int at);
        fexp_t e;
        e.ch = ch; e.data = d; e.at = at;
        exp_f.push_back(e);
    endtask

    task automatic push_c(input logic rd, input logic [DW-1:0] d, input int at);
        cexp_t e;
        e.rd = rd; e.data = d; e.at = at;
        exp_c.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        fexp_t fe;
        cexp_t ce;
        if (!resetp) begin
            for (int i = 0; i < NCH; i++) begin
                if (fetch_valid[i]) begin
                    if (exp_f.size() == 0) begin
                        chk("fv_spurious", {31'b0, fetch_valid[i]}, 32'd0);
                    end else begin
                        fe = exp_f.pop_front();
                        chk("fv_ch", i, fe.ch);
                        chk("fv_cyc", cyc, fe.at);
                        chk("fv_data", fetch_data[i*DW +: DW], fe.data);
                    end
                end
            end
            if (cpu_done) begin
                if (exp_c.size() == 0) begin
                    chk("done_spurious", {31'b0, cpu_done}, 32'd0);
                end else begin
                    ce = exp_c.pop_front();
                    chk("done_cyc", cyc, ce.at);
                    chk("done_busy", cpu_busy, 0);
                    if (ce.rd) chk("cpu_rdata", cpu_rdata, ce.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetp     = 1'b1;
        fetch_en   = 3'b111;
        fetch_addr = {15'h7002, 15'h7001, 15'h7000};
        cpu_req    = 1'b0;
        cpu_wr     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
`ifdef SLOW_VRAM_AUTOINC_EN
        cpu_ald    = 1'b0;
        cpu_mod    = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_slot", slot, 0);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_done", cpu_done, 0);
        chk("rst_oe_we", {mem_oe, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_fdata", {31'b0, |fetch_data}, 0);
        chk("rst_rdata", cpu_rdata, 0);

        // frame 0: all three channels fetch, CPU slot idle
        push_f(0, 16'h7000, 4);
        push_f(1, 16'h7001, 8);
        push_f(2, 16'h7002, 12);
        resetp = 1'b0;
        at_cyc(1);  chk("f0_oe", mem_oe, 1); chk("f0_addr", mem_addr, 15'h7000);
        at_cyc(4);  chk("f1_oe", mem_oe, 1); chk("f1_addr", mem_addr, 15'h7001); chk("f1_slot", slot, 1);
        at_cyc(13); chk("cpu_idle_slot", slot, 3); chk("cpu_idle_oe_we", {mem_oe, mem_we}, 0);

        // frame 1: only channel 1 enabled, new address
        at_cyc(15);
        fetch_en = 3'b010;
        fetch_addr[AW +: AW] = 15'h0055;
        push_f(1, 16'h0055, 24);
        at_cyc(16); chk("idle0_oe", mem_oe, 0); chk("idle0_addr_hold", mem_addr, 15'h7002);
        at_cyc(20); chk("en1_oe", mem_oe, 1); chk("en1_addr", mem_addr, 15'h0055);
        at_cyc(24); chk("idle2_oe", mem_oe, 0);
        at_cyc(26);
        chk("hold_fd0", fetch_data[0*DW +: DW], 16'h7000);
        chk("new_fd1", fetch_data[1*DW +: DW], 16'h0055);
        chk("hold_fd2", fetch_data[2*DW +: DW], 16'h7002);
        at_cyc(31); fetch_en = 3'b000;

        // CPU write accepted at frame clock 11
        at_cyc(43);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 16'hBEEF;
        push_c(1'b0, 16'h0000, 48);
        at_cyc(44);
        chk("wr_busy", cpu_busy, 1); chk("wr_ph0_we", mem_we, 0); chk("wr_ph0_oe", mem_oe, 0);
        chk("wr_addr", mem_addr, 15'h1234); chk("wr_wdata", mem_wdata, 16'hBEEF);
        cpu_req = 1'b0;
        at_cyc(45); chk("wr_ph1_we", mem_we, 1); chk("wr_ph1_oe", mem_oe, 0);
        at_cyc(46); chk("wr_ph2_we", mem_we, 1);
        at_cyc(47); chk("wr_ph3_we", mem_we, 0);

        // read back, accepted on the DONE clock
        at_cyc(48);
        chk("done_clk_busy", cpu_busy, 0);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h1234;
        push_c(1'b1, 16'hBEEF, 64);
        at_cyc(49); chk("rd_busy", cpu_busy, 1); cpu_req = 1'b0;
        at_cyc(60); chk("rd_oe", mem_oe, 1); chk("rd_we", mem_we, 0); chk("rd_addr", mem_addr, 15'h1234);
        at_cyc(63); chk("rd_oe_last", mem_oe, 1);

        // accept on CPU slot phase 0 waits a frame; second request while busy is ignored
        at_cyc(76);
        chk("late_idle_oe", mem_oe, 0);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h0055;
        push_c(1'b1, 16'h0055, 96);
        at_cyc(77); chk("late_busy", cpu_busy, 1); chk("late_slot_oe", mem_oe, 0); cpu_addr = 15'h0AAA;
        at_cyc(79); cpu_req = 1'b0;
        at_cyc(92); chk("late_oe", mem_oe, 1); chk("late_addr", mem_addr, 15'h0055);

        // reset in phase 2 of a CPU write slot
        at_cyc(105);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'h0300; cpu_wdata = 16'h1111;
        at_cyc(106); cpu_req = 1'b0;
        at_cyc(110); chk("mid_we", mem_we, 1); chk("mid_slot", slot, 3);
        resetp = 1'b1;
        @(negedge clk);
        chk("mrst_we", mem_we, 0); chk("mrst_oe", mem_oe, 0); chk("mrst_busy", cpu_busy, 0);
        chk("mrst_slot", slot, 0); chk("mrst_done", cpu_done, 0);
        chk("mrst_fdata", {31'b0, |fetch_data}, 0); chk("mrst_rdata", cpu_rdata, 0);
        resetp = 1'b0;
        at_cyc(12); chk("discard_oe_we", {mem_oe, mem_we}, 0); chk("discard_busy", cpu_busy, 0);

`ifdef SLOW_VRAM_AUTOINC_EN
        at_cyc(21);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_ald = 1'b1; cpu_addr = 15'h7FFF; cpu_mod = 15'h0001;
        cpu_wdata = 16'hA5A5;
        push_c(1'b0, 16'h0000, 32);
        at_cyc(22); cpu_req = 1'b0; cpu_ald = 1'b0;
        at_cyc(28); chk("ai_load_addr", mem_addr, 15'h7FFF);
        at_cyc(32);
        cpu_req = 1'b1; cpu_wdata = 16'h5A5A;
        push_c(1'b0, 16'h0000, 48);
        at_cyc(33); cpu_req = 1'b0; cpu_mod = 15'h7FFF;
        at_cyc(44); chk("ai_wrap_addr", mem_addr, 15'h0000);
        at_cyc(48);
        cpu_req = 1'b1; cpu_wdata = 16'h3C3C;
        push_c(1'b0, 16'h0000, 64);
        at_cyc(49); cpu_req = 1'b0; chk("ai_wrap_mem", mem[0], 16'h5A5A);
        at_cyc(60); chk("ai_dec_addr", mem_addr, 15'h7FFF);
        at_cyc(66);
`else
        at_cyc(20);
`endif
        chk("sb_empty", exp_f.size() + exp_c.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/slow_vram_scheduler.md
# slow_vram_scheduler

Parametrised time-slot sequencer for the slow (120 ns) VRAM bank; the generalised successor to the fixed fix-map, sprite-map and CPU interleave in the video path. It divides CLK_24M into a repeating frame of NCH fetch slots plus one CPU slot and drives the single-ported SRAM. It latches each channel's read word and serves one buffered CPU read or write per frame through a request/busy/done handshake.

## Interface
Parameters:
- ADDR_W, 15, VRAM word address width
- DATA_W, 16, VRAM data width
- NCH, 3, number of video fetch channels (1..8)
- SLOT_LEN, 4, CLK_24M cycles per slot (≥3)

Ports:
- CLK_24M  in  1  sole clock, rising edge
- RESETP  in  1  synchronous, active-high reset
- FETCH_EN  in  NCH  per-channel enable, sampled at phase 0 of that channel's slot
- FETCH_ADDR  in  NCH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
- FETCH_DATA  out  NCH*DATA_W  per-channel read latch
- FETCH_VALID  out  NCH  one-clock pulse when FETCH_DATA[i] updates
- CPU_REQ, CPU_WR  in  1  access request; 1 = write
- CPU_ADDR  in  ADDR_W  CPU address
- CPU_WDATA  in  DATA_W  CPU write data
- CPU_BUSY  out  1  buffer occupied
- CPU_DONE  out  1  one-clock completion pulse
- CPU_RDATA  out  DATA_W  last CPU read word
- SLOT  out  clog2(NCH+1)  current slot index
- MEM_ADDR  out  ADDR_W  SRAM address
- MEM_WDATA  out  DATA_W  SRAM write data
- MEM_RDATA  in  DATA_W  SRAM read data
- MEM_OE, MEM_WE  out  1  active-high enables; the board wrapper inverts them

## Operation
- Phase counter 0..SLOT_LEN-1 advances every clock. At the last phase, SLOT advances and wraps NCH→0. Slots 0..NCH-1 are fetch slots for channels 0..NCH-1. Slot NCH is the CPU slot.
- Slot start (phase 0): the slot owner is sampled. If it is active, MEM_ADDR is registered and held for the whole slot. An idle slot leaves MEM_ADDR unchanged and keeps MEM_OE/MEM_WE low.
- Fetch slot i, FETCH_EN[i]=1:
  - MEM_OE is high for phases 0..SLOT_LEN-1.
  - MEM_RDATA is captured into FETCH_DATA[i] at the end of the last phase.
  - FETCH_VALID[i] is high the following clock.
  - Other channels' latches hold their values.
- CPU handshake:
  - With CPU_BUSY=0 and CPU_REQ=1, the buffer latches CPU_WR, the address and the data, and CPU_BUSY rises next clock.
  - CPU_REQ while CPU_BUSY=1 is ignored; there is no queue.
  - The access executes in the first CPU slot whose phase 0 is strictly after acceptance. An accept on the same clock as the CPU slot's phase 0 waits one frame.
- CPU read: same MEM_OE pattern as a fetch; data is captured into CPU_RDATA.
- CPU write:
  - MEM_WDATA is driven for the whole slot.
  - MEM_OE stays low.
  - MEM_WE is high only for phases 1..SLOT_LEN-2, giving address setup and hold.
- Completion: CPU_DONE pulses the clock after the slot's last phase, and CPU_BUSY falls on that same clock. A new request is accepted on that clock.
- Reset values:
  - Phase 0, SLOT=0.
  - All FETCH_DATA, CPU_RDATA, MEM_ADDR, MEM_WDATA = 0.
  - All enables, VALID, BUSY, DONE = 0.
  - Buffer empty.
- Reset mid-slot drops MEM_WE/MEM_OE on the next clock and discards a pending or in-flight CPU access with no DONE.

## Timing
- Frame = (NCH+1)*SLOT_LEN clocks; 16 clocks with the defaults, 667 ns.
- Fetch latency: slot start to FETCH_VALID = SLOT_LEN clocks.
- CPU latency, accept to DONE:
  - Minimum SLOT_LEN+1, when accepted one clock before the CPU slot.
  - Maximum frame+SLOT_LEN, when accepted on the CPU slot's phase 0.
- At most one MEM_OE/MEM_WE slot is active at any time; MEM_OE and MEM_WE are never both high.

## Configuration
- SLOW_VRAM_AUTOINC_EN defined:
  - Adds inputs CPU_ALD (1) and CPU_MOD (ADDR_W, two's complement) and an internal address pointer.
  - An accepted request with CPU_ALD=1 loads the pointer from CPU_ADDR. With CPU_ALD=0 the request uses the current pointer.
  - On each CPU_DONE, pointer ← pointer + CPU_MOD, modulo 2^ADDR_W. Wrap is silent.
  - This models the LSPC VRAMADDR/VRAMMOD behaviour.
- Undefined: no pointer and no extra ports; every access uses CPU_ADDR as latched at accept.

## Structure
- Package slow_vram_pkg holds:
  - SLOT_W/PHASE_W width functions (clog2).
  - FRAME_LEN(nch, slot_len) function.
  - Phase-role constants (PH_ADDR=0, PH_WE_FIRST=1, PH_CAPTURE=SLOT_LEN-1).
- Sub-module slow_vram_slot_timer: phase and slot counters with slot_start/slot_end strobes.
- The top level holds the per-channel latches, the CPU buffer and the SRAM drive.

## Test plan
- Defaults. Release reset, FETCH_EN=3'b111, FETCH_ADDR = {15'h7002, 15'h7001, 15'h7000}, memory model returns data equal to the address → FETCH_VALID[0..2] at clocks 4, 8, 12 after reset release; FETCH_DATA = 16'h7000/7001/7002; idle CPU slot.
- FETCH_EN=3'b010 → only slot 1 asserts MEM_OE; FETCH_DATA[0] and [2] hold their old values; no VALID[0] or VALID[2].
- CPU write addr 15'h1234, data 16'hBEEF accepted at frame clock 11 → MEM_WE high at clocks 13–14 only, MEM_OE low, DONE at clock 16. A following read of 15'h1234 returns 16'hBEEF.
- CPU_REQ accepted exactly at clock 12 (CPU slot phase 0) → executes the next frame; DONE 20 clocks later. A second CPU_REQ while busy is ignored.
- Assert RESETP at phase 2 of a CPU write slot → MEM_WE low next clock, no CPU_DONE, CPU_BUSY=0, SLOT=0.
- With SLOW_VRAM_AUTOINC_EN: load addr 15'h7FFF, CPU_MOD=1, two writes → second write lands at 15'h0000 (wrap); with CPU_MOD=15'h7FFF (−1) the pointer decrements.
